// File: rtl/i2c_byte_ctrl_if.sv
// Signal bundle between the I2C core control / shift register and the byte sequencer.
// The slave modport is the sequencer's view; master is the view of the logic around it.
interface i2c_byte_ctrl_if;
    logic scl_rise;
    logic scl_fall;
    logic sda_in;
    logic stop_det;
    logic cmd_start;
    logic cmd_tx;
    logic ack_en;
    logic ack_go;
    logic sr_msb;
    logic sr_load;
    logic sr_shift_en;
    logic sr_serial_in;
    logic sda_oe;
    logic scl_hold;
    logic busy;
    logic byte_rcvd;
    logic byte_done;
    logic ack_rcvd;

    modport slave (
        input  scl_rise, scl_fall, sda_in, stop_det, cmd_start, cmd_tx, ack_en, ack_go, sr_msb,
        output sr_load, sr_shift_en, sr_serial_in, sda_oe, scl_hold, busy, byte_rcvd, byte_done,
               ack_rcvd
    );

    modport master (
        output scl_rise, scl_fall, sda_in, stop_det, cmd_start, cmd_tx, ack_en, ack_go, sr_msb,
        input  sr_load, sr_shift_en, sr_serial_in, sda_oe, scl_hold, busy, byte_rcvd, byte_done,
               ack_rcvd
    );
endinterface

// File: rtl/i2c_byte_ctrl.sv
// Byte-level I2C bit sequencer: drives the 8-bit shift register, SDA and the ACK bit.
// Define I2C_BYTE_CTRL_STRETCH_EN to stretch SCL after a received byte until ack_go.
module i2c_byte_ctrl (
    input  logic           clk,
    input  logic           asyn_rst,
    i2c_byte_ctrl_if.slave bus
);
    localparam int unsigned CNT_W = 4;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        TX_BIT,
        TX_ACK,
        RX_BIT,
`ifdef I2C_BYTE_CTRL_STRETCH_EN
        RX_HOLD,
`endif
        RX_ACK
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             sr_load_q;
    logic             sr_shift_en_q;
    logic             sr_serial_in_q;
    logic             sda_oe_q;
    logic             scl_hold_q;
    logic             busy_q;
    logic             byte_rcvd_q;
    logic             byte_done_q;
    logic             ack_rcvd_q;

    // Coincident rise and fall pulses are treated as noise and dropped.
    logic scl_rise_c;
    logic scl_fall_c;
    assign scl_rise_c = bus.scl_rise & ~bus.scl_fall;
    assign scl_fall_c = bus.scl_fall & ~bus.scl_rise;

`ifndef I2C_BYTE_CTRL_STRETCH_EN
    logic unused_ack_go;
    assign unused_ack_go = bus.ack_go;
`endif

    always_ff @(posedge clk or posedge asyn_rst) begin
        if (asyn_rst) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            sr_load_q      <= 1'b0;
            sr_shift_en_q  <= 1'b0;
            sr_serial_in_q <= 1'b0;
            sda_oe_q       <= 1'b0;
            scl_hold_q     <= 1'b0;
            busy_q         <= 1'b0;
            byte_rcvd_q    <= 1'b0;
            byte_done_q    <= 1'b0;
            ack_rcvd_q     <= 1'b1;
        end else begin
            sr_load_q      <= 1'b0;
            sr_shift_en_q  <= 1'b0;
            sr_serial_in_q <= 1'b0;
            byte_rcvd_q    <= 1'b0;
            byte_done_q    <= 1'b0;
            if (bus.stop_det) begin
                state_q    <= IDLE;
                cnt_q      <= '0;
                sda_oe_q   <= 1'b0;
                scl_hold_q <= 1'b0;
                busy_q     <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        cnt_q <= '0;
                        if (bus.cmd_start) begin
                            busy_q <= 1'b1;
                            if (bus.cmd_tx) begin
                                state_q   <= LOAD;
                                sr_load_q <= 1'b1;
                            end else begin
                                state_q <= RX_BIT;
                            end
                        end
                    end
                    LOAD: state_q <= TX_BIT;
                    // Bit 7 sits at the register MSB; SDA follows it until the 8th falling edge.
                    TX_BIT: begin
                        sda_oe_q <= ~bus.sr_msb;
                        if (scl_fall_c) begin
                            if (cnt_q == CNT_W'(7)) begin
                                cnt_q    <= '0;
                                sda_oe_q <= 1'b0;
                                state_q  <= TX_ACK;
                            end else begin
                                sr_shift_en_q <= 1'b1;
                                cnt_q         <= cnt_q + CNT_W'(1);
                            end
                        end
                    end
                    TX_ACK: begin
                        sda_oe_q <= 1'b0;
                        if (scl_rise_c) begin
                            ack_rcvd_q <= bus.sda_in;
                        end
                        if (scl_fall_c) begin
                            byte_done_q <= 1'b1;
                            busy_q      <= 1'b0;
                            state_q     <= IDLE;
                        end
                    end
                    RX_BIT: begin
                        sda_oe_q <= 1'b0;
                        if (scl_rise_c && cnt_q != CNT_W'(8)) begin
                            sr_shift_en_q  <= 1'b1;
                            sr_serial_in_q <= bus.sda_in;
                            cnt_q          <= cnt_q + CNT_W'(1);
                        end else if (scl_fall_c && cnt_q == CNT_W'(8)) begin
                            byte_rcvd_q <= 1'b1;
`ifdef I2C_BYTE_CTRL_STRETCH_EN
                            scl_hold_q  <= 1'b1;
                            state_q     <= RX_HOLD;
`else
                            sda_oe_q    <= bus.ack_en;
                            state_q     <= RX_ACK;
`endif
                        end
                    end
`ifdef I2C_BYTE_CTRL_STRETCH_EN
                    // SCL stays low so firmware can read the byte before choosing ACK/NACK.
                    RX_HOLD: begin
                        scl_hold_q <= 1'b1;
                        sda_oe_q   <= 1'b0;
                        if (bus.ack_go) begin
                            scl_hold_q <= 1'b0;
                            sda_oe_q   <= bus.ack_en;
                            state_q    <= RX_ACK;
                        end
                    end
`endif
                    RX_ACK: begin
                        if (scl_fall_c) begin
                            sda_oe_q    <= 1'b0;
                            byte_done_q <= 1'b1;
                            busy_q      <= 1'b0;
                            cnt_q       <= '0;
                            state_q     <= IDLE;
                        end
                    end
                    default: begin
                        state_q  <= IDLE;
                        cnt_q    <= '0;
                        sda_oe_q <= 1'b0;
                        busy_q   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.sr_load      = sr_load_q;
    assign bus.sr_shift_en  = sr_shift_en_q;
    assign bus.sr_serial_in = sr_serial_in_q;
    assign bus.sda_oe       = sda_oe_q;
    assign bus.scl_hold     = scl_hold_q;
    assign bus.busy         = busy_q;
    assign bus.byte_rcvd    = byte_rcvd_q;
    assign bus.byte_done    = byte_done_q;
    assign bus.ack_rcvd     = ack_rcvd_q;
endmodule
